// File: rtl/nn_job_arbiter_if.sv
// ---------------------------------------------------------------------------
// nn_job_arbiter_if
//   Bundles the client-side request/response signals and the neural network
//   core handshake of nn_job_arbiter.
//   slave  : arbiter view (takes requests, drives responses and the core)
//   master : environment view (clients and core)
//   Signals:
//     req_valid/req_data/req_ready   per-requester job request and accept
//     rsp_valid/rsp_data/rsp_error   one-hot response strobe, result, timeout flag
//     nn_start/nn_input_data         launch pulse and job inputs to the core
//     nn_output_data/nn_valid_out    core result and result strobe
//     nn_ready                       core idle
// ---------------------------------------------------------------------------
interface nn_job_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 24,
    parameter int OUT_W   = 16
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IN_W-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [OUT_W-1:0]        rsp_data;
    logic                    rsp_error;
    logic                    nn_start;
    logic [IN_W-1:0]         nn_input_data;
    logic [OUT_W-1:0]        nn_output_data;
    logic                    nn_valid_out;
    logic                    nn_ready;

    modport slave (
        input  req_valid, req_data, nn_output_data, nn_valid_out, nn_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error, nn_start, nn_input_data
    );

    modport master (
        output req_valid, req_data, nn_output_data, nn_valid_out, nn_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error, nn_start, nn_input_data
    );
endinterface

// File: rtl/nn_job_arbiter.sv
// ---------------------------------------------------------------------------
// nn_job_arbiter
//   Shares a single neural network core among NUM_REQ requesters. A
//   round-robin search picks one pending request, the job is launched with a
//   one-cycle nn_start pulse, the core result is awaited and then returned
//   with a one-cycle strobe on the winning requester's rsp_valid bit.
//   Only one job is in flight at a time.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    nn_job_arbiter_if.slave (requests, responses, core handshake)
//
//   Configuration macro NN_ARB_TIMEOUT_EN:
//     defined   - a job whose result does not arrive within the timeout
//                 window is answered with rsp_data = 0 and rsp_error = 1.
//     undefined - no timeout counter; rsp_error is tied to 0.
// ---------------------------------------------------------------------------
module nn_job_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 24,
    parameter int OUT_W   = 16
`ifdef NN_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 20
`endif
) (
    input logic             clk,
    input logic             rst_n,
    nn_job_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [PTR_W-1:0]   gnt_r;
    logic [PTR_W-1:0]   win_s;
    logic [PTR_W-1:0]   idx_s;
    logic [PTR_W-1:0]   rr_next_s;
    logic               found_s;
    logic               hit_s;
    logic               accept_s;
    logic               wait_done_s;
    logic               tmo_hit_s;
    logic [NUM_REQ-1:0] win_onehot_s;
    logic [NUM_REQ-1:0] gnt_onehot_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic [IN_W-1:0]    win_data_s;
    logic [IN_W-1:0]    nn_input_data_r;
    logic [OUT_W-1:0]   rsp_data_r;
    logic [NUM_REQ-1:0] rsp_valid_r;
    logic               nn_start_r;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        found_s = 1'b0;
        win_s   = {PTR_W{1'b0}};
        idx_s   = {PTR_W{1'b0}};
        hit_s   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s   = PTR_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            hit_s   = bus.req_valid[idx_s] & ~found_s;
            win_s   = hit_s ? idx_s : win_s;
            found_s = found_s | hit_s;
        end
    end

    // Select the winner's job inputs; other requesters' data is never looked at.
    always_comb begin
        win_data_s = {IN_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            win_data_s = (PTR_W'(k) == win_s) ? bus.req_data[k*IN_W +: IN_W] : win_data_s;
        end
    end

    // Grant decode; rst_n gates req_ready so no accept is offered during reset.
    always_comb begin
        win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
        gnt_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_r;
        rr_next_s    = (win_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : win_s + PTR_W'(1);
        accept_s     = rst_n & (state_r == S_IDLE) & bus.nn_ready & found_s;
        req_ready_s  = accept_s ? win_onehot_s : {NUM_REQ{1'b0}};
        wait_done_s  = (state_r == S_WAIT) & (bus.nn_valid_out | tmo_hit_s);
    end

    // Next-state logic of the job sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:   state_s = accept_s ? S_LAUNCH : S_IDLE;
            S_LAUNCH: state_s = S_WAIT;
            S_WAIT:   state_s = wait_done_s ? S_RESP : S_WAIT;
            S_RESP:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // State, grant bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            rr_ptr_r        <= {PTR_W{1'b0}};
            gnt_r           <= {PTR_W{1'b0}};
            nn_input_data_r <= {IN_W{1'b0}};
            rsp_data_r      <= {OUT_W{1'b0}};
            rsp_valid_r     <= {NUM_REQ{1'b0}};
            nn_start_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            nn_start_r  <= accept_s;
            rsp_valid_r <= wait_done_s ? gnt_onehot_s : {NUM_REQ{1'b0}};
            if (accept_s) begin
                rr_ptr_r        <= rr_next_s;
                gnt_r           <= win_s;
                nn_input_data_r <= win_data_s;
            end
            if (wait_done_s) begin
                // A real result wins over a timeout hitting in the same cycle.
                rsp_data_r <= bus.nn_valid_out ? bus.nn_output_data : {OUT_W{1'b0}};
            end
        end
    end

`ifdef NN_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [CNT_W-1:0] tmo_cnt_r;
    logic             rsp_error_r;

    // The count is 0 in the first WAIT cycle, so the abort lands TIMEOUT_CYC+2 cycles after nn_start.
    assign tmo_hit_s = (state_r == S_WAIT) & ~bus.nn_valid_out & (tmo_cnt_r == CNT_W'(TIMEOUT_CYC));

    // WAIT-cycle counter and the error flag that qualifies the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r   <= {CNT_W{1'b0}};
            rsp_error_r <= 1'b0;
        end else begin
            if (state_r == S_LAUNCH) begin
                tmo_cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == S_WAIT) && !wait_done_s) begin
                tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
            end
            if (wait_done_s) begin
                rsp_error_r <= tmo_hit_s;
            end
        end
    end

    assign bus.rsp_error = rsp_error_r;
`else
    assign tmo_hit_s     = 1'b0;
    assign bus.rsp_error = 1'b0;
`endif

    assign bus.req_ready     = req_ready_s;
    assign bus.rsp_valid     = rsp_valid_r;
    assign bus.rsp_data      = rsp_data_r;
    assign bus.nn_start      = nn_start_r;
    assign bus.nn_input_data = nn_input_data_r;

endmodule

// File: tb/tb_nn_job_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nn_job_arbiter
//   Directed bench for nn_job_arbiter with NUM_REQ = 4. A behavioural core
//   answers the four known job vectors after a fixed latency; expected
//   responses are queued when stimulus is issued and a monitor compares them
//   whenever rsp_valid is seen. A second monitor checks the launch pulse and
//   the data handed to the core after every accept.
// ---------------------------------------------------------------------------
module tb_nn_job_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IN_W    = 24;
    localparam int OUT_W   = 16;
`ifdef NN_ARB_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 20;
`endif

    typedef struct {
        int          idx;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   rsp_seen = 0;
    int   rsp_cyc = 0;
    int   start_cyc = 0;
    exp_t exp_q[$];
    exp_t e_mon;

    // behavioural core state
    logic        core_busy  = 1'b0;
    logic [1:0]  core_cnt   = 2'd0;
    logic [15:0] core_res   = 16'h0000;
    logic        core_dead  = 1'b0;
    logic        force_busy = 1'b0;
    logic        stray_req  = 1'b0;

    // accept tracking for the launch monitor
    logic        pend_acc  = 1'b0;
    logic [23:0] pend_data = 24'h0;
    logic [3:0]  acc_mon;

    nn_job_arbiter_if #(.NUM_REQ(NUM_REQ), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    nn_job_arbiter #(.NUM_REQ(NUM_REQ), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] nn_model(input logic [23:0] x);
        case (x)
            24'h010203: return 16'h5051;
            24'h030201: return 16'h4E4D;
            24'h000000: return 16'h0707;
            24'hFFFEFD: return 16'h0101;
            default:    return 16'hDEAD;
        endcase
    endfunction

    assign bus.nn_ready = ~core_busy & ~force_busy;

    // Core model: three cycles after the launch edge it strobes the result.
    always @(posedge clk) begin
        bus.nn_valid_out <= stray_req;
        bus.nn_output_data <= stray_req ? 16'hBAD0 : bus.nn_output_data;
        if (core_busy) begin
            if (core_cnt == 2'd0) begin
                core_busy          <= 1'b0;
                bus.nn_valid_out   <= 1'b1;
                bus.nn_output_data <= core_res;
            end else begin
                core_cnt <= core_cnt - 2'd1;
            end
        end else if (bus.nn_start === 1'b1 && !core_dead) begin
            core_busy <= 1'b1;
            core_cnt  <= 2'd2;
            core_res  <= nn_model(bus.nn_input_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: every strobe pops one expected response.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.rsp_valid !== 4'b0000) begin
            rsp_seen++;
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b data=%h, expected no response", bus.rsp_valid, bus.rsp_data);
            end else begin
                e_mon = exp_q.pop_front();
                check("rsp_valid", {28'h0, bus.rsp_valid}, 32'h1 << e_mon.idx);
                check("rsp_data", {16'h0, bus.rsp_data}, {16'h0, e_mon.data});
                check("rsp_error", {31'h0, bus.rsp_error}, {31'h0, e_mon.err});
            end
        end
    end

    // Launch monitor: nn_start exactly one cycle after an accept, carrying the winner's data.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            pend_acc = 1'b0;
        end else begin
            check("nn_start", {31'h0, bus.nn_start}, {31'h0, pend_acc});
            if (pend_acc) check("nn_input_data", {8'h0, bus.nn_input_data}, {8'h0, pend_data});
            if (bus.nn_start === 1'b1) start_cyc = cyc;
            acc_mon  = bus.req_valid & bus.req_ready;
            pend_acc = 1'b0;
            if (acc_mon != 4'b0000) begin
                check("req_ready_onehot", {31'h0, $onehot(acc_mon)}, 32'h1);
                pend_acc = 1'b1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (acc_mon[k]) pend_data = bus.req_data[k*IN_W +: IN_W];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Present requests until n_acc accepts have been seen (bounded).
    task automatic run_reqs(input string name, input logic [3:0] mask, input logic drop_on_accept,
                            input int n_acc, input logic [95:0] data);
        int got = 0;
        int budget = 0;
        logic [3:0] acc;
        bus.req_data  = data;
        bus.req_valid = mask;
        while (got < n_acc && budget < 2000) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            got += $countones(acc);
            tick();
            if (drop_on_accept) bus.req_valid = bus.req_valid & ~acc;
            budget++;
        end
        bus.req_valid = 4'b0000;
        check({name, "_accepts"}, got, n_acc);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic push(input int idx, input logic [15:0] data, input logic err);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int n;
        bus.req_valid = 4'b1111;
        bus.req_data  = 96'h0;
        rst_n = 1'b0;
        tick();
        tick();
        // reset state, with requests pending to prove req_ready is held low
        check("rst_req_ready", {28'h0, bus.req_ready}, 32'h0);
        check("rst_rsp_valid", {28'h0, bus.rsp_valid}, 32'h0);
        check("rst_nn_start", {31'h0, bus.nn_start}, 32'h0);
        check("rst_rsp_error", {31'h0, bus.rsp_error}, 32'h0);
        check("rst_rsp_data", {16'h0, bus.rsp_data}, 32'h0);
        check("rst_nn_input_data", {8'h0, bus.nn_input_data}, 32'h0);
        bus.req_valid = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();

        // single job from requester 0
        push(0, 16'h5051, 1'b0);
        run_reqs("t1", 4'b0001, 1'b1, 1, {72'h0, 24'h010203});
        drain("t1");

        // all four at once from a fresh pointer: order 0,1,2,3, pointer wraps 3->0
        do_reset();
        push(0, 16'h5051, 1'b0);
        push(1, 16'h4E4D, 1'b0);
        push(2, 16'h0707, 1'b0);
        push(3, 16'h0101, 1'b0);
        run_reqs("t2", 4'b1111, 1'b1, 4, {24'hFFFEFD, 24'h000000, 24'h030201, 24'h010203});
        drain("t2");

        // two requesters held for six jobs: strict alternation
        for (int i = 0; i < 3; i++) begin
            push(0, 16'h5051, 1'b0);
            push(2, 16'h0707, 1'b0);
        end
        run_reqs("t3", 4'b0101, 1'b0, 6, {24'h123456, 24'h000000, 24'h654321, 24'h010203});
        drain("t3");

        // core busy: no grant, stray nn_valid_out ignored, grant right after nn_ready rises
        force_busy = 1'b1;
        stray_req  = 1'b1;
        bus.req_data  = {24'h0, 24'h0, 24'h030201, 24'h0};
        bus.req_valid = 4'b0010;
        push(1, 16'h4E4D, 1'b0);
        tick();
        stray_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6_no_grant", {28'h0, bus.req_ready}, 32'h0);
            tick();
        end
        force_busy = 1'b0;
        @(negedge clk);
        check("t6_grant", {28'h0, bus.req_ready}, 32'h2);
        tick();
        bus.req_valid = 4'b0000;
        drain("t6");

        // core that never answers
        core_dead = 1'b1;
`ifdef NN_ARB_TIMEOUT_EN
        push(2, 16'h0000, 1'b1);
`endif
        r0 = rsp_seen;
        run_reqs("t4", 4'b0100, 1'b1, 1, {24'h0, 24'h010203, 24'h0, 24'h0});
`ifdef NN_ARB_TIMEOUT_EN
        n = 0;
        while (rsp_seen == r0 && n < 200) begin
            tick();
            n++;
        end
        check("t4_rsp_count", rsp_seen - r0, 1);
        check("t4_latency", rsp_cyc - start_cyc, TIMEOUT_CYC + 2);
        drain("t4");
`else
        n = 0;
        while (n < 100) begin
            tick();
            n++;
        end
        check("t4_no_rsp", rsp_seen - r0, 0);
        do_reset();
`endif
        core_dead = 1'b0;

        // reset during WAIT of a requester 1 job; then requester 3 completes normally
        r0 = rsp_seen;
        run_reqs("t5a", 4'b0010, 1'b1, 1, {24'h0, 24'h0, 24'h030201, 24'h0});
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_req_ready", {28'h0, bus.req_ready}, 32'h0);
        check("t5_rst_rsp_valid", {28'h0, bus.rsp_valid}, 32'h0);
        check("t5_rst_nn_start", {31'h0, bus.nn_start}, 32'h0);
        check("t5_rst_rsp_error", {31'h0, bus.rsp_error}, 32'h0);
        check("t5_rst_rsp_data", {16'h0, bus.rsp_data}, 32'h0);
        check("t5_rst_nn_input_data", {8'h0, bus.nn_input_data}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push(3, 16'h0707, 1'b0);
        run_reqs("t5b", 4'b1000, 1'b1, 1, {24'h000000, 24'h0, 24'h0, 24'h0});
        drain("t5");
        check("t5_rsp_count", rsp_seen - r0, 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
